// File: rtl/spi_xfer_ctrl.sv
// rtl/spi_xfer_ctrl.sv - SPI mode-0 master sequencer, one command in, one RX word out (option: SPI_XFER_CTRL_MSB_FIRST_EN)
module spi_xfer_ctrl #(
    parameter int NSS   = 8,
    parameter int DIV_W = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [$clog2(NSS):0] cmd_ss,
    input  logic [4:0]           cmd_len,
    input  logic [DIV_W-1:0]     cmd_div,
    input  logic [31:0]          cmd_tx,
`ifdef SPI_XFER_CTRL_MSB_FIRST_EN
    input  logic                 cmd_msb,
`endif
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_rx,
    output logic                 busy,
    output logic                 sck,
    output logic [NSS-1:0]       ss,
    output logic                 mosi,
    input  logic                 miso
);

    localparam int SS_W = $clog2(NSS) + 1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        TAIL,
        RESP
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_q;
    logic [4:0]       len_q;
    logic [4:0]       bit_cnt;
    logic [31:0]      tx_q;
    logic [31:0]      rx;
    logic [NSS-1:0]   ss_dec;
`ifdef SPI_XFER_CTRL_MSB_FIRST_EN
    logic             msb_q;
`endif

    // Maps the serial position of a bit to its word index; MSB-first keeps the word right-aligned
    function automatic logic [4:0] bit_idx(input logic [4:0] b);
`ifdef SPI_XFER_CTRL_MSB_FIRST_EN
        return msb_q ? (len_q - b) : b;
`else
        return b;
`endif
    endfunction

    // Active-low one-hot select for the offered index; out-of-range indices select nothing
    always_comb begin
        ss_dec = '1;
        for (int i = 0; i < NSS; i++) begin
            if (cmd_ss == i[SS_W-1:0]) begin
                ss_dec[i] = 1'b0;
            end
        end
    end

    // Transfer sequencer: every output is registered and updated on phase changes
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            div_q     <= '0;
            len_q     <= '0;
            bit_cnt   <= '0;
            tx_q      <= '0;
            rx        <= '0;
            sck       <= 1'b0;
            ss        <= '1;
            mosi      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rx    <= '0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
`ifdef SPI_XFER_CTRL_MSB_FIRST_EN
            msb_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        state     <= SETUP;
                        cnt       <= '0;
                        div_q     <= cmd_div;
                        len_q     <= cmd_len;
                        tx_q      <= cmd_tx;
                        bit_cnt   <= '0;
                        rx        <= '0;
                        ss        <= ss_dec;
                        sck       <= 1'b0;
                        busy      <= 1'b1;
                        cmd_ready <= 1'b0;
`ifdef SPI_XFER_CTRL_MSB_FIRST_EN
                        msb_q     <= cmd_msb;
                        mosi      <= cmd_msb ? cmd_tx[cmd_len] : cmd_tx[0];
`else
                        mosi      <= cmd_tx[0];
`endif
                    end
                end
                SETUP, LOW: begin
                    if (cnt == div_q) begin
                        cnt   <= '0;
                        state <= HIGH;
                        sck   <= 1'b1;
                    end else begin
                        cnt <= cnt + DIV_W'(1);
                    end
                end
                HIGH: begin
                    if (cnt == div_q) begin
                        // Sample just before the falling edge so a rising-edge slave is settled
                        cnt              <= '0;
                        sck              <= 1'b0;
                        rx[bit_idx(bit_cnt)] <= miso;
                        if (bit_cnt == len_q) begin
                            state <= TAIL;
                        end else begin
                            state   <= LOW;
                            bit_cnt <= bit_cnt + 5'd1;
                            mosi    <= tx_q[bit_idx(bit_cnt + 5'd1)];
                        end
                    end else begin
                        cnt <= cnt + DIV_W'(1);
                    end
                end
                TAIL: begin
                    if (cnt == div_q) begin
                        cnt       <= '0;
                        state     <= RESP;
                        ss        <= '1;
                        mosi      <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rx    <= rx;
                    end else begin
                        cnt <= cnt + DIV_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    sck       <= 1'b0;
                    ss        <= '1;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb/tb_spi_xfer_ctrl.sv - directed self-checking bench for spi_xfer_ctrl
module tb_spi_xfer_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_ss;
    logic [4:0]  cmd_len;
    logic [7:0]  cmd_div;
    logic [31:0] cmd_tx;
`ifdef SPI_XFER_CTRL_MSB_FIRST_EN
    logic        cmd_msb;
`endif
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rx;
    logic        busy;
    logic        sck;
    logic [7:0]  ss;
    logic        mosi;
    logic        miso;
    logic        loop_en;
    logic        miso_val;

    int checks = 0;
    int errors = 0;

    // results of the last monitored transfer
    int          t_rsp;
    int          rises;
    int          hi_min, hi_max, lo_min, lo_max;
    int          mosi_bad;
    int          ss_bad;
    logic [7:0]  ss_at1;
    logic [31:0] seq;
    logic [31:0] rx_got;

    assign miso = loop_en ? mosi : miso_val;

    always #5 clock = ~clock;

    spi_xfer_ctrl #(.NSS(8), .DIV_W(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_ss    (cmd_ss),
        .cmd_len   (cmd_len),
        .cmd_div   (cmd_div),
        .cmd_tx    (cmd_tx),
`ifdef SPI_XFER_CTRL_MSB_FIRST_EN
        .cmd_msb   (cmd_msb),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rx    (rsp_rx),
        .busy      (busy),
        .sck       (sck),
        .ss        (ss),
        .mosi      (mosi),
        .miso      (miso)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_sck"}, {31'd0, sck}, 32'd0);
        check({tag, "_ss"}, {24'd0, ss}, 32'h0000_00FF);
        check({tag, "_mosi"}, {31'd0, mosi}, 32'd0);
        check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    // Issue one command and watch the pins cycle by cycle until rsp_valid (t counted from the handshake)
    task automatic run_xfer(input logic [3:0] s, input logic [4:0] l, input logic [7:0] d,
                            input logic [31:0] tx, input logic msb);
        logic prev_sck;
        logic prev_mosi;
        int   hi_run;
        int   lo_run;
        bit   seen_high;
        @(negedge clock);
        cmd_ss    = s;
        cmd_len   = l;
        cmd_div   = d;
        cmd_tx    = tx;
`ifdef SPI_XFER_CTRL_MSB_FIRST_EN
        cmd_msb   = msb;
`else
        if (msb) $display("note: msb-first requested in an LSB-only build");
`endif
        cmd_valid = 1'b1;
        @(posedge clock);
        #1;
        // scramble the command bus: the latched copy must be used
        cmd_valid = 1'b0;
        cmd_div   = 8'd0;
        cmd_len   = 5'd0;
        cmd_tx    = 32'h0;
        t_rsp = -1; rises = 0; mosi_bad = 0; ss_bad = 0; seq = '0;
        hi_min = 9999; hi_max = 0; lo_min = 9999; lo_max = 0;
        hi_run = 0; lo_run = 0; seen_high = 0;
        prev_sck = 1'b0; prev_mosi = mosi; ss_at1 = 8'h00;
        for (int t = 1; t < 2000; t++) begin
            @(negedge clock);
            if (t == 1) ss_at1 = ss;
            else if (!rsp_valid && ss !== ss_at1) ss_bad++;
            if (sck && mosi !== prev_mosi) mosi_bad++;
            if (sck && !prev_sck) begin
                if (rises < 32) seq[rises] = mosi;
                rises++;
                if (seen_high) begin
                    if (lo_run < lo_min) lo_min = lo_run;
                    if (lo_run > lo_max) lo_max = lo_run;
                end
                hi_run = 0;
            end
            if (!sck && prev_sck) begin
                if (hi_run < hi_min) hi_min = hi_run;
                if (hi_run > hi_max) hi_max = hi_run;
                lo_run = 0;
                seen_high = 1;
            end
            if (sck) hi_run++; else lo_run++;
            prev_sck  = sck;
            prev_mosi = mosi;
            if (rsp_valid) begin
                t_rsp = t;
                break;
            end
        end
        rx_got = rsp_rx;
    endtask

    task automatic consume();
        @(negedge clock);
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
    endtask

    initial begin
        int bad_stable, bad_ready, bad_sck;
        logic [31:0] held;
        reset = 1'b1; cmd_valid = 1'b0; cmd_ss = '0; cmd_len = '0; cmd_div = '0; cmd_tx = '0;
`ifdef SPI_XFER_CTRL_MSB_FIRST_EN
        cmd_msb = 1'b0;
`endif
        rsp_ready = 1'b0; loop_en = 1'b1; miso_val = 1'b0;
        repeat (3) @(negedge clock);
        check_idle("reset");
        check("reset_rsp_rx", rsp_rx, 32'd0);
        reset = 1'b0;

        // 8-bit loopback at full speed
        run_xfer(4'd0, 5'd7, 8'd0, 32'h0000_00A5, 1'b0);
        check("a5_rx", rx_got, 32'h0000_00A5);
        check("a5_ss_t1", {24'd0, ss_at1}, 32'h0000_00FE);
        check("a5_ss_steady", ss_bad, 32'd0);
        check("a5_rises", rises, 32'd8);
        check("a5_t_rsp", t_rsp, 32'd18);
        check("a5_mosi_order", seq, 32'h0000_00A5);
        check("a5_mosi_hold", mosi_bad, 32'd0);
        check("a5_ss_at_rsp", {24'd0, ss}, 32'h0000_00FF);
        consume();
        check_idle("a5_done");

        // 32-bit loopback, H = 4, then stall the response
        run_xfer(4'd5, 5'd31, 8'd3, 32'hDEAD_BEEF, 1'b0);
        check("beef_rx", rx_got, 32'hDEAD_BEEF);
        check("beef_ss_t1", {24'd0, ss_at1}, 32'h0000_00DF);
        check("beef_rises", rises, 32'd32);
        check("beef_t_rsp", t_rsp, 32'd261);
        check("beef_hi_min", hi_min, 32'd4);
        check("beef_hi_max", hi_max, 32'd4);
        check("beef_lo_min", lo_min, 32'd4);
        check("beef_lo_max", lo_max, 32'd4);
        check("beef_mosi_order", seq, 32'hDEAD_BEEF);
        held = rsp_rx;
        bad_stable = 0; bad_ready = 0; bad_sck = 0;
        cmd_ss = 4'd1; cmd_len = 5'd3; cmd_tx = 32'h5; cmd_div = 8'd0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            cmd_valid = (k == 3 || k == 4);
            if (rsp_rx !== held || !rsp_valid) bad_stable++;
            if (cmd_ready !== 1'b0 || busy !== 1'b1) bad_ready++;
            if (sck !== 1'b0 || ss !== 8'hFF) bad_sck++;
        end
        cmd_valid = 1'b0;
        check("stall_rx_stable", bad_stable, 32'd0);
        check("stall_not_ready", bad_ready, 32'd0);
        check("stall_no_sck", bad_sck, 32'd0);
        consume();
        check_idle("stall_done");
        @(negedge clock);
        check("stall_cmd_ignored", {31'd0, busy}, 32'd0);

        // out-of-range select, miso tied high
        loop_en = 1'b0; miso_val = 1'b1;
        run_xfer(4'd9, 5'd3, 8'd0, 32'h0000_0000, 1'b0);
        check("oor_rx", rx_got, 32'h0000_000F);
        check("oor_ss_t1", {24'd0, ss_at1}, 32'h0000_00FF);
        check("oor_ss_steady", ss_bad, 32'd0);
        check("oor_rises", rises, 32'd4);
        check("oor_t_rsp", t_rsp, 32'd10);
        consume();
        loop_en = 1'b1;

        // reset in the middle of a transfer
        @(negedge clock);
        cmd_ss = 4'd3; cmd_len = 5'd15; cmd_div = 8'd1; cmd_tx = 32'hFFFF; cmd_valid = 1'b1;
        @(negedge clock);
        cmd_valid = 1'b0;
        repeat (6) @(negedge clock);
        check("mid_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_idle("mid_reset");
        check("mid_reset_rsp_rx", rsp_rx, 32'd0);

        // one-bit transfer after the aborted one: RX must start clean
        run_xfer(4'd2, 5'd0, 8'd0, 32'h0000_0001, 1'b0);
        check("one_rx", rx_got, 32'h0000_0001);
        check("one_ss_t1", {24'd0, ss_at1}, 32'h0000_00FB);
        check("one_t_rsp", t_rsp, 32'd4);
        consume();

`ifdef SPI_XFER_CTRL_MSB_FIRST_EN
        run_xfer(4'd0, 5'd7, 8'd0, 32'h0000_0001, 1'b1);
        check("msb_rx", rx_got, 32'h0000_0001);
        check("msb_mosi_order", seq, 32'h0000_0080);
        check("msb_rises", rises, 32'd8);
        consume();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_xfer_ctrl.md
Name: spi_xfer_ctrl

Overview:
- SPI master sequencer for the SoC-sim serial peripherals (bit-reverse slave and similar).
- Accepts one command per transfer: slave index, bit count, clock divider and TX word.
- Generates ss/sck/mosi in SPI mode 0, LSB-first, and captures miso into an RX word.
- Returns the RX word on a valid/ready response channel; exactly one transfer is in flight at a time.

Parameters:
- NSS, 8, number of slave-select lines; cmd_ss width = clog2(NSS) + 1 so out-of-range indices are encodable.
- DIV_W, 8, width of the half-period divider field.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  controller idle and able to accept a command.
- cmd_ss  in  clog2(NSS)+1  slave index.
- cmd_len  in  5  bit count minus 1 (0 -> 1 bit, 31 -> 32 bits).
- cmd_div  in  DIV_W  half-period H = cmd_div + 1 clock cycles.
- cmd_tx  in  32  TX data; bit 0 is sent first.
- rsp_valid  out  1  RX result available.
- rsp_ready  in  1  response consumed.
- rsp_rx  out  32  RX data; bit i = miso captured at SCK edge i.
- busy  out  1  high whenever state != IDLE.
- sck  out  1  SPI clock; idles low.
- ss  out  NSS  active-low selects; idle all ones.
- mosi  out  1  master data out.
- miso  in  1  slave data in.

Behaviour:
- Reset values: sck=0, ss=all 1, mosi=0, rsp_valid=0, rsp_rx=0, busy=0, cmd_ready=1, state=IDLE. All outputs are registered.
- cmd_ready = (state == IDLE). A handshake is cmd_valid & cmd_ready in cycle t=0. cmd_ss, cmd_len, cmd_div and cmd_tx are latched at t=0.
- States:
  - IDLE -> SETUP on handshake.
  - SETUP (H cycles): ss[cmd_ss]=0, sck=0, mosi=tx[0]. Then go to HIGH.
  - HIGH (H cycles): sck=1. In the last cycle of HIGH, miso is sampled into rx[bit].
  - If bit == len, HIGH -> TAIL. Otherwise HIGH -> LOW.
  - LOW (H cycles): sck=0, bit increments, mosi=tx[bit] from the first LOW cycle. Then go to HIGH.
  - TAIL (H cycles): sck=0, ss still asserted. Then go to RESP.
  - RESP: ss=all 1, rsp_valid=1, rsp_rx held stable until rsp_ready. RESP -> IDLE on handshake.
- Timing:
  - ss falls at t=1.
  - sck rises first at t=1+H.
  - Exactly len+1 sck rising edges per transfer.
  - rsp_valid rises at t = 1 + (2*(len+1)+1)*H, in the same cycle ss returns high.
- mosi changes only while sck is low. miso is sampled just before each falling edge, so a slave updating miso on the rising edge is captured safely.
- rsp_rx bits above len are 0. The internal rx register is cleared at command accept.
- cmd_ss >= NSS: no ss line is asserted, but sck/mosi sequence normally and a response is still returned with the captured miso.
- cmd_valid during any non-IDLE state is ignored (cmd_ready=0); there is no queueing.
- cmd_div is latched per command; changing cmd_div mid-transfer has no effect.
- Divider counter: counts 0..H-1 within each phase and reloads on every phase change. With cmd_div=0, sck = clock/2.
- Reset mid-transfer: the next cycle shows ss=all 1, sck=0, mosi=0, rsp_valid=0 and state=IDLE. The partial RX word is discarded.

Optional Feature:
- Macro SPI_XFER_CTRL_MSB_FIRST_EN.
- Defined: adds input port cmd_msb (1 bit), latched at accept. When cmd_msb=1, bits are sent from tx[len] down to tx[0], and the miso bit from edge i lands in rx[len-i], so the word is right-aligned in both cases.
- Undefined: the port is absent and transfers are LSB-first only.

Test Plan:
- Reset -> sck=0, ss=8'hFF, mosi=0, rsp_valid=0, cmd_ready=1, busy=0. Repeat the check after asserting reset mid-transfer.
- Loopback (miso=mosi) with cmd_ss=0, cmd_len=7, cmd_div=0, cmd_tx=32'hA5 -> rsp_rx=32'h000000A5. ss[0] low from t=1, 8 sck rises, rsp_valid at t=18.
- Loopback with cmd_len=31, cmd_div=3, cmd_tx=32'hDEADBEEF -> rsp_rx=32'hDEADBEEF, each sck high/low phase lasts 4 cycles, rsp_valid at t=1+65*4=261.
- rsp_ready held low 10 cycles after rsp_valid -> rsp_rx stable, cmd_ready=0, a concurrent cmd_valid pulse is ignored, and no sck activity occurs.
- cmd_ss=9 with miso tied 1, cmd_len=3 -> ss stays 8'hFF, 4 sck pulses, rsp_rx=32'h0000000F.
- MSB_FIRST_EN build: cmd_msb=1, cmd_len=7, tx=8'h01, loopback -> mosi is 1 only during the last bit, rsp_rx=32'h01.
